// File: rtl/mem_arbiter_rv.sv
// Two-master (fetch/data) arbiter in front of the DRAM user interface; one transaction in flight.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module mem_arbiter_rv #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_x,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic              o_if_ack,
    output logic [DATA_W-1:0] o_if_rdata,
    input  logic              i_d_req,
    input  logic              i_d_we,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    input  logic [2:0]        i_d_ctrl,
    output logic              o_d_ack,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_m_rd_en,
    output logic              o_m_wr_en,
    output logic [ADDR_W-1:0] o_m_addr,
    output logic [DATA_W-1:0] o_m_data,
    output logic [2:0]        o_m_ctrl,
    input  logic [DATA_W-1:0] i_m_data,
    input  logic              i_m_busy,
    input  logic              i_m_calib_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_RESP
    } state_t;

    state_t            state_q;
    logic              gnt_d_q;   // 1 = data port holds / last held the grant
    logic              we_q;
    logic              rd_en_q, wr_en_q, if_ack_q, d_ack_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q, if_rdata_q, d_rdata_q;
    logic [2:0]        ctrl_q;

    logic              win_d_d;
    logic              we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] data_d;
    logic [2:0]        ctrl_d;
    logic              issue_ok;

    assign issue_ok = i_m_calib_done && !i_m_busy && (i_if_req || i_d_req);

    always_comb begin
        win_d_d = i_d_req;
`ifdef MEM_ARB_RR_EN
        if (i_d_req && i_if_req) win_d_d = ~gnt_d_q;
`else
`endif
        if (win_d_d) begin
            addr_d = i_d_addr;
            data_d = i_d_wdata;
            ctrl_d = i_d_ctrl;
            we_d   = i_d_we;
        end else begin
            // fetches are always full-word reads
            addr_d = i_if_addr;
            data_d = '0;
            ctrl_d = 3'b010;
            we_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            state_q    <= S_IDLE;
            gnt_d_q    <= 1'b1;
            we_q       <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            ctrl_q     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (issue_ok) begin
                        addr_q  <= addr_d;
                        data_q  <= data_d;
                        ctrl_q  <= ctrl_d;
                        we_q    <= we_d;
                        gnt_d_q <= win_d_d;
                        rd_en_q <= ~we_d;
                        wr_en_q <= we_d;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rd_en_q <= 1'b0;
                    wr_en_q <= 1'b0;
                    state_q <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (i_m_busy) state_q <= S_WAIT_LO;
                end
                S_WAIT_LO: begin
                    if (!i_m_busy) begin
                        if (gnt_d_q) begin
                            if (!we_q) d_rdata_q <= i_m_data;
                            d_ack_q <= 1'b1;
                        end else begin
                            if_rdata_q <= i_m_data;
                            if_ack_q   <= 1'b1;
                        end
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if_ack_q <= 1'b0;
                    d_ack_q  <= 1'b0;
                    state_q  <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_if_ack   = if_ack_q;
    assign o_if_rdata = if_rdata_q;
    assign o_d_ack    = d_ack_q;
    assign o_d_rdata  = d_rdata_q;
    assign o_m_rd_en  = rd_en_q;
    assign o_m_wr_en  = wr_en_q;
    assign o_m_addr   = addr_q;
    assign o_m_data   = data_q;
    assign o_m_ctrl   = ctrl_q;

endmodule
